// File: rtl/issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : issue_queue                                                  |
// | Description : Collapsing reservation-station issue queue for one           |
// |               functional unit. Accepts dispatched instructions, snoops     |
// |               the CDB for pending operands, and offers the oldest ready    |
// |               instruction to the execution unit.                           |
// | Ports       : clk, reset (async, active-low), [flush],                     |
// |               dispatch_* (write side), CDB_* (wakeup broadcast),           |
// |               issue_ready (EU accept), issueque_full (back-pressure),      |
// |               issue_* (offered instruction, zero when not valid).          |
// | Config      : ISSUEQUE_FLUSH_EN adds the 1-bit flush input, which clears   |
// |               every entry and the count at the next rising edge.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module issue_queue #(
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int OPCODE_WIDTH = 4,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef ISSUEQUE_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    dispatch_en,
    input  logic [OPCODE_WIDTH-1:0] dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]    dispatch_rd_tag,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs1_data,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs1_tag,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs2_tag,
    input  logic                    dispatch_rs1_valid,
    input  logic                    dispatch_rs2_valid,
    input  logic                    CDB_valid,
    input  logic [TAG_WIDTH-1:0]    CDB_tag,
    input  logic [DATA_WIDTH-1:0]   CDB_data,
    input  logic                    issue_ready,
    output logic                    issueque_full,
    output logic                    issue_valid,
    output logic [OPCODE_WIDTH-1:0] issue_opcode,
    output logic [TAG_WIDTH-1:0]    issue_rd_tag,
    output logic [DATA_WIDTH-1:0]   issue_rs1_data,
    output logic [DATA_WIDTH-1:0]   issue_rs2_data
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [TAG_WIDTH-1:0]    rd_tag;
        logic [DATA_WIDTH-1:0]   rs1_data;
        logic [TAG_WIDTH-1:0]    rs1_tag;
        logic                    rs1_rdy;
        logic [DATA_WIDTH-1:0]   rs2_data;
        logic [TAG_WIDTH-1:0]    rs2_tag;
        logic                    rs2_rdy;
    } entry_t;

    entry_t               r_entry_q [DEPTH];
    entry_t               w_entry_d [DEPTH];
    entry_t               w_woken   [DEPTH];
    entry_t               w_new;
    logic [c_cnt_w-1:0]   r_count_q;
    logic [c_cnt_w-1:0]   w_count_d;
    logic [c_cnt_w-1:0]   w_sel_idx;
    logic [c_cnt_w-1:0]   w_ins_idx;
    logic                 w_found;
    logic                 w_fire;
    logic                 w_accept;

    // Oldest-first select: scan downward so the lowest ready index wins.
    // Only registered ready bits are used, so the CDB never reaches issue_valid.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((c_cnt_w'(i) < r_count_q) && r_entry_q[i].rs1_rdy && r_entry_q[i].rs2_rdy) begin
                w_found   = 1'b1;
                w_sel_idx = c_cnt_w'(i);
            end
        end
    end

    always_comb begin
        issue_opcode   = '0;
        issue_rd_tag   = '0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_found && (c_cnt_w'(i) == w_sel_idx)) begin
                issue_opcode   = r_entry_q[i].opcode;
                issue_rd_tag   = r_entry_q[i].rd_tag;
                issue_rs1_data = r_entry_q[i].rs1_data;
                issue_rs2_data = r_entry_q[i].rs2_data;
            end
        end
    end

    assign issue_valid   = w_found;
    assign issueque_full = (r_count_q == c_depth);
    assign w_fire        = w_found && issue_ready;
    assign w_accept      = dispatch_en && (r_count_q < c_depth);
    // After a collapse the first free slot moves down by one.
    assign w_ins_idx     = w_fire ? (r_count_q - 1'b1) : r_count_q;

    // Incoming entry, including same-cycle CDB bypass for pending operands.
    always_comb begin
        w_new          = '0;
        w_new.opcode   = dispatch_opcode;
        w_new.rd_tag   = dispatch_rd_tag;
        w_new.rs1_tag  = dispatch_rs1_tag;
        w_new.rs2_tag  = dispatch_rs2_tag;
        w_new.rs1_rdy  = dispatch_rs1_valid;
        w_new.rs2_rdy  = dispatch_rs2_valid;
        w_new.rs1_data = dispatch_rs1_valid ? dispatch_rs1_data : '0;
        w_new.rs2_data = dispatch_rs2_valid ? dispatch_rs2_data : '0;
        if (!dispatch_rs1_valid && CDB_valid && (dispatch_rs1_tag == CDB_tag)) begin
            w_new.rs1_rdy  = 1'b1;
            w_new.rs1_data = CDB_data;
        end
        if (!dispatch_rs2_valid && CDB_valid && (dispatch_rs2_tag == CDB_tag)) begin
            w_new.rs2_rdy  = 1'b1;
            w_new.rs2_data = CDB_data;
        end
    end

    // Next-state: wakeup, then collapse over the issued slot, then insert.
    // A wakeup landing on the issued entry is simply overwritten by the shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i] = r_entry_q[i];
            if (CDB_valid && (c_cnt_w'(i) < r_count_q)) begin
                if (!r_entry_q[i].rs1_rdy && (r_entry_q[i].rs1_tag == CDB_tag)) begin
                    w_woken[i].rs1_rdy  = 1'b1;
                    w_woken[i].rs1_data = CDB_data;
                end
                if (!r_entry_q[i].rs2_rdy && (r_entry_q[i].rs2_tag == CDB_tag)) begin
                    w_woken[i].rs2_rdy  = 1'b1;
                    w_woken[i].rs2_data = CDB_data;
                end
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            w_entry_d[i] = w_woken[i];
        end
        if (w_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (c_cnt_w'(i) >= w_sel_idx) begin
                    w_entry_d[i] = w_woken[i + 1];
                end
            end
            // Slots at or above count are kept zero, so clearing the top
            // slot keeps that invariant after the shift.
            w_entry_d[DEPTH-1] = '0;
        end

        if (w_accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (c_cnt_w'(i) == w_ins_idx) begin
                    w_entry_d[i] = w_new;
                end
            end
        end

        w_count_d = r_count_q + c_cnt_w'(w_accept) - c_cnt_w'(w_fire);

`ifdef ISSUEQUE_FLUSH_EN
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_entry_d[i] = '0;
            end
            w_count_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry_q[i] <= '0;
            end
            r_count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry_q[i] <= w_entry_d[i];
            end
            r_count_q <= w_count_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/issue_queue.md
# issue_queue

Reservation-station issue queue for one functional unit (integer, ld/st, mul or div), one instance per unit. It is the receiving end of the dispatch interface: it accepts instructions from the dispatch unit, holds them until both source operands are available, snoops the CDB to capture pending operands, and issues the oldest ready instruction to its execution unit. Back-pressure to dispatch is through `issueque_full`.

## Interface
- `DATA_WIDTH`, 32: operand width.
- `TAG_WIDTH`, 6: ROB/CDB tag width.
- `OPCODE_WIDTH`, 4: dispatch opcode width.
- `DEPTH`, 4: number of entries, ≥2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dispatch_en`  in  1  write one instruction this cycle.
- `dispatch_opcode`  in  OPCODE_WIDTH  opcode.
- `dispatch_rd_tag`  in  TAG_WIDTH  destination tag.
- `dispatch_rs1_data` / `dispatch_rs2_data`  in  DATA_WIDTH  operand values, meaningful when the matching valid bit is 1.
- `dispatch_rs1_tag` / `dispatch_rs2_tag`  in  TAG_WIDTH  producer tags, meaningful when the matching valid bit is 0.
- `dispatch_rs1_valid` / `dispatch_rs2_valid`  in  1  operand already available.
- `CDB_valid`  in  1  broadcast valid.
- `CDB_tag`  in  TAG_WIDTH  broadcast tag.
- `CDB_data`  in  DATA_WIDTH  broadcast value.
- `issue_ready`  in  1  execution unit accepts this cycle.
- `issueque_full`  out  1  queue holds DEPTH entries.
- `issue_valid`  out  1  `issue_*` carries an instruction.
- `issue_opcode`  out  OPCODE_WIDTH  opcode of the offered instruction.
- `issue_rd_tag`  out  TAG_WIDTH  destination tag.
- `issue_rs1_data` / `issue_rs2_data`  out  DATA_WIDTH  operand values.

## Operation
- Collapsing queue. Entries 0..count-1 are valid, with entry 0 the oldest. Each entry holds opcode, rd_tag, and per operand: data, tag and a ready bit.
- **Count:** `count` is a register of width $clog2(DEPTH+1).
- **Accept:** an instruction is accepted when `dispatch_en` is high and `count < DEPTH`. `dispatch_en` while full is a protocol violation: the instruction is dropped and state is unchanged.
- **Wakeup:** when `CDB_valid` is high, every valid entry operand with ready=0 and tag == `CDB_tag` captures `CDB_data` and sets ready=1.
- **Same-cycle bypass:** a dispatched operand with valid=0 whose tag equals `CDB_tag` while `CDB_valid` is high is written with `CDB_data` and ready=1.
- **Select:** the lowest-index entry with both ready bits set. `issue_valid` = such an entry exists. `issue_*` are driven combinationally from that entry, and are all-zero when `issue_valid` = 0.
- **Issue:** occurs when `issue_valid` and `issue_ready` are both high. Entries above the issued index shift down by one; the vacated top slot is invalidated.
- **New entry placement:** written at index count (no issue this cycle) or count-1 (issue this cycle), after the collapse.
- **Count update:** +1 on accept only; -1 on issue only; unchanged on both or neither.
- **Flag:** `issueque_full` = (count == DEPTH), decoded from the count register.

## Timing
- **Reset:** all entries invalid and count = 0. Outputs after reset: `issueque_full`=0, `issue_valid`=0, all `issue_*` data/tag/opcode = 0.
- **Dispatch with both operands valid:** entry written at edge N. `issue_valid`=1 in cycle N+1. Minimum latency is 1 cycle.
- **CDB wakeup:** a broadcast in cycle N makes the entry eligible in cycle N+1. Ready bits are registered; the CDB never feeds `issue_valid` combinationally.
- **Full flag:** `issueque_full` rises in the cycle after the DEPTH-th accept, and falls in the cycle after an issue from full.
- **Accept and issue in the same cycle:** when not full, both happen and count is unchanged. When full, the dispatch is still dropped, because the dispatch unit must observe `issueque_full`.
- **Stall:** while `issue_ready`=0 the offered instruction and the `issue_*` values hold stable, unless an older entry becomes ready; older-first then takes priority.
- **CDB matching issued entry:** if the CDB matches the entry being issued in the same cycle, the wakeup is discarded along with the entry.
- **Reset mid-operation:** asserting `reset` clears all entries immediately (asynchronously). In-flight instructions are lost.

## Configuration
- `ISSUEQUE_FLUSH_EN` defined: adds input port `flush` (1 bit), placed after `reset`. When `flush`=1 at a clock edge, all entries are invalidated and count is set to 0, overriding accept and issue that cycle. Outputs are zero from the next cycle. This is used for branch-mispredict recovery.
- `ISSUEQUE_FLUSH_EN` undefined: no `flush` port and no flush logic.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles → `issueque_full`=0, `issue_valid`=0, `issue_rs1_data`=0.
- **Ready dispatch:** dispatch opcode 4'h3, rd_tag 6'd5, rs1=32'h10 valid, rs2=32'h20 valid, with `issue_ready`=1 → next cycle `issue_valid`=1, `issue_opcode`=3, `issue_rd_tag`=5, data 0x10/0x20. The cycle after that, `issue_valid`=0.
- **Wakeup:** dispatch with rs1 tag 6'd9 not valid. Two cycles later, CDB_valid with tag 9 and data 32'hABCD → `issue_valid`=1 one cycle after the broadcast, with `issue_rs1_data`=0xABCD.
- **Same-cycle bypass:** dispatch rs2 tag 6'd7 not valid while CDB broadcasts tag 7 with data 32'h55 → issues the next cycle with `issue_rs2_data`=0x55.
- **Full and ordering:** with `issue_ready`=0, dispatch 4 ready instructions with rd_tags 1..4 → `issueque_full`=1. A 5th dispatch is dropped. Then raise `issue_ready` → rd_tags issue in order 1,2,3,4, and `issueque_full` falls after the first issue.
- **Out-of-order and simultaneous:** entry 0 is waiting on tag 12 and entry 1 is ready → entry 1 issues first. A dispatch in the same cycle lands at index 1, and count stays 2.
